decoder_scan_ctrl: RTL
======================

Name: decoder_scan_ctrl

Overview:
- Sequencer directly upstream of the 4-to-16 decoder.
- Generates the 4-bit select (d,c,b,a) and the enable that step the decoder through all 16 outputs in order.
- Each row is held active for a programmable dwell, followed by an optional blanking gap with enable low.
- Supports single-sweep and continuous-scan modes, for row/column scanning of displays and keypads.

Parameters:
- DWELL, 4, cycles en is high per row; legal range 1..255.
- BLANK, 1, cycles en is low between consecutive rows; legal range 0..255; 0 = no gap.
- CNT_W, 8, width of the internal dwell/blank counter; DWELL and BLANK must fit.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  sampled each cycle; begins a sweep when idle.
- stop  input  1  sampled each cycle; aborts the sweep.
- mode  input  1  0 = single sweep, 1 = continuous; latched when start is accepted.
- d  output  1  select bit 3 (MSB), to decoder.
- c  output  1  select bit 2.
- b  output  1  select bit 1.
- a  output  1  select bit 0 (LSB).
- e  output  1  decoder enable.
- row_done  output  1  one-cycle pulse on the last enabled cycle of each row.
- sweep_done  output  1  one-cycle pulse on the last enabled cycle of row 15.
- busy  output  1  high while in ACTIVE or BLANK.

Behaviour:
- Reset (async, any state): state=IDLE; {d,c,b,a}=0; e=0; row_done=0; sweep_done=0; busy=0; counter=0; latched mode=0. All outputs are registered.
- States: IDLE, ACTIVE, BLANK.
- IDLE:
  - e=0, sel=0, busy=0.
  - start=1 and stop=0 -> ACTIVE next cycle with sel=0, e=1, counter=0, mode latched.
  - start and stop both 1 -> stop wins; remain IDLE.
- ACTIVE:
  - e=1, sel held, counter increments each cycle.
  - On the cycle where counter==DWELL-1: row_done=1; if sel==15, sweep_done=1 as well.
  - Next state after the last dwell cycle:
    - sel<15 and BLANK>0 -> BLANK.
    - sel<15 and BLANK==0 -> ACTIVE with sel+1; e stays high and the counter restarts at 0.
    - sel==15, single mode -> IDLE (sel returns to 0; no trailing blank).
    - sel==15, continuous mode -> BLANK if BLANK>0, else ACTIVE with sel wrapped to 0.
- BLANK:
  - e=0, sel held at the previous row, busy=1.
  - After BLANK cycles -> ACTIVE with sel+1 (mod 16), e=1.
- Select timing: sel changes only on the edge where e rises, or where the row changes with BLANK==0. e is never high with a sel value mid-transition.
- Latency: first e=1 is the cycle after start is sampled.
- Row period is DWELL+BLANK cycles.
- Single sweep occupies 16*DWELL+15*BLANK cycles of busy.
- stop=1 in ACTIVE or BLANK:
  - Next cycle is IDLE with e=0, sel=0, busy=0.
  - row_done and sweep_done are suppressed in the stop cycle, even if it would have been a row end.
- start while busy: ignored; mode is not re-latched.
- Changing mode while busy has no effect.
- In continuous mode, sweep_done pulses once per pass.
- rst asserted mid-sweep: all outputs go to reset values immediately; no pulses are generated.

Test Plan:
1. DWELL=4, BLANK=1, mode=0, start pulsed at cycle 0:
   - row k has e=1 with sel=k on cycles 1+5k..4+5k, and e=0 on cycle 5+5k.
   - row_done on cycles 4+5k.
   - sweep_done and row_done on cycle 79; busy=0 and sel=0 from cycle 80.
2. Same setup with mode=1:
   - cycle 80 has e=0 and sel=15; cycle 81 has sel=0, e=1.
   - second sweep_done on cycle 159; continues until stop.
3. DWELL=4, BLANK=0, mode=0:
   - e high continuously for cycles 1..64; sel increments every 4 cycles (sel=3 on cycles 13..16).
   - sweep_done on cycle 64.
4. Stop mid-row at cycle 22 (sel=4, counter 1):
   - cycle 23 has e=0, sel=0, busy=0.
   - no further row_done; sweep_done never pulses.
   - a start/stop coincident in IDLE leaves the block idle.
5. start re-pulsed at cycle 30 with mode toggled:
   - no effect; the sweep completes exactly as in scenario 1.
6. rst asserted asynchronously between edges at cycle ~40:
   - e, sel, busy and the pulses drop to 0 without waiting for a clock edge.
   - after release, start produces a fresh sweep beginning at sel=0.

Source files
------------

// File: rtl/decoder_scan_ctrl_if.sv
// Control and select bundle between the scan sequencer and its 4-to-16 decoder.
// The master drives start/stop/mode; the slave (sequencer) drives select, enable and status.
interface decoder_scan_ctrl_if;
    logic start;
    logic stop;
    logic mode;
    logic d;
    logic c;
    logic b;
    logic a;
    logic e;
    logic row_done;
    logic sweep_done;
    logic busy;

    modport master (
        output start, stop, mode,
        input  d, c, b, a, e, row_done, sweep_done, busy
    );

    modport slave (
        input  start, stop, mode,
        output d, c, b, a, e, row_done, sweep_done, busy
    );
endinterface

// File: rtl/decoder_scan_ctrl.sv
// Steps a 4-to-16 decoder through rows 0..15: DWELL cycles enabled per row, BLANK cycles gap.
// Latency: first enabled cycle follows the cycle start is sampled; all outputs registered.
// No backpressure: runs free once started; stop aborts to idle on the next edge.
module decoder_scan_ctrl #(
    parameter int DWELL = 4,
    parameter int BLANK = 1,
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    decoder_scan_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_BLANK
    } state_t;

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK > 0) ? BLANK - 1 : 0);

    state_t           state_q, state_n;
    logic [3:0]       sel_q, sel_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic             mode_q, mode_n;
    logic             e_q, e_n;
    logic             busy_q, busy_n;
    logic             row_done_q, row_done_n;
    logic             sweep_done_q, sweep_done_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            sel_q        <= '0;
            cnt_q        <= '0;
            mode_q       <= 1'b0;
            e_q          <= 1'b0;
            busy_q       <= 1'b0;
            row_done_q   <= 1'b0;
            sweep_done_q <= 1'b0;
        end else begin
            state_q      <= state_n;
            sel_q        <= sel_n;
            cnt_q        <= cnt_n;
            mode_q       <= mode_n;
            e_q          <= e_n;
            busy_q       <= busy_n;
            row_done_q   <= row_done_n;
            sweep_done_q <= sweep_done_n;
        end
    end

    always_comb begin
        state_n = state_q;
        sel_n   = sel_q;
        cnt_n   = cnt_q + 1'b1;
        mode_n  = mode_q;

        unique case (state_q)
            ST_IDLE: begin
                sel_n = '0;
                cnt_n = '0;
                if (bus.start && !bus.stop) begin
                    state_n = ST_ACTIVE;
                    mode_n  = bus.mode;
                end
            end
            ST_ACTIVE: begin
                if (bus.stop) begin
                    state_n = ST_IDLE;
                    sel_n   = '0;
                    cnt_n   = '0;
                end else if (cnt_q == DWELL_LAST) begin
                    cnt_n = '0;
                    if (sel_q == 4'd15 && !mode_q) begin
                        state_n = ST_IDLE;
                        sel_n   = '0;
                    end else if (BLANK > 0) begin
                        state_n = ST_BLANK;
                    end else begin
                        // No gap: advance the row on the same edge so e stays high.
                        sel_n = sel_q + 4'd1;
                    end
                end
            end
            ST_BLANK: begin
                if (bus.stop) begin
                    state_n = ST_IDLE;
                    sel_n   = '0;
                    cnt_n   = '0;
                end else if (cnt_q == BLANK_LAST) begin
                    state_n = ST_ACTIVE;
                    sel_n   = sel_q + 4'd1;
                    cnt_n   = '0;
                end
            end
            default: begin
                state_n = ST_IDLE;
                sel_n   = '0;
                cnt_n   = '0;
            end
        endcase

        // Outputs are registered, so derive them from the state being entered.
        e_n          = (state_n == ST_ACTIVE);
        busy_n       = (state_n != ST_IDLE);
        row_done_n   = (state_n == ST_ACTIVE) && (cnt_n == DWELL_LAST);
        sweep_done_n = row_done_n && (sel_n == 4'd15);
    end

    assign {bus.d, bus.c, bus.b, bus.a} = sel_q;
    assign bus.e          = e_q;
    assign bus.busy       = busy_q;
    assign bus.row_done   = row_done_q;
    assign bus.sweep_done = sweep_done_q;

endmodule
